// File: rtl/display_message_sequencer.sv
// Frame scheduler for the 4-digit ASCII display: buffers up to DEPTH packed
// 4-character frames, then plays them in write order, each held HOLD_LAST+1 cycles.
module display_message_sequencer #(
    parameter int            CRYSTAL   = 100,
    parameter int            HOLD_SEC  = 1,
    parameter int            C         = 35,
    parameter logic [C-1:0]  HOLD_LAST = C'(64'(CRYSTAL) * 64'd1_000_000 * 64'(HOLD_SEC) - 64'd1),
    parameter int            DEPTH     = 8,
    parameter int            AW        = 3,
    parameter logic [31:0]   BLANK     = 32'h20202020
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    output logic          wr_ready,
    input  logic          clear,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic          busy,
    output logic [AW-1:0] frame_idx,
    output logic [AW:0]   count,
    output logic [31:0]   packed_ascii,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t        state, state_d;
    logic [31:0]   mem [DEPTH];
    logic [C-1:0]  hold, hold_d;
    logic [AW-1:0] frame_idx_d, idx_inc;
    logic [AW:0]   count_d;
    logic          busy_d, done_d;
    logic [31:0]   packed_ascii_d;
    logic          do_clear, do_write, do_start, hold_end, last_frame;

    // Write handshake: a frame is taken on a rising edge where wr_en && wr_ready;
    // wr_ready depends only on state and count, never on wr_en.
    assign wr_ready   = (state == IDLE) && (count < (AW+1)'(DEPTH));
    assign do_clear   = (state == IDLE) && clear;
    assign do_write   = wr_en && wr_ready && !clear;
    // Start looks at the pre-write count; clear in the same cycle empties the buffer, so it blocks start.
    assign do_start   = (state == IDLE) && start && !clear && (count != '0);
    assign hold_end   = (hold == HOLD_LAST);
    assign last_frame = ({1'b0, frame_idx} == (count - (AW+1)'(1)));
    assign idx_inc    = frame_idx + AW'(1);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (do_start) state_d = SHOW;
            SHOW: begin
                if (stop)                               state_d = IDLE;
                else if (hold_end && last_frame && !loop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_d         = hold;
        frame_idx_d    = frame_idx;
        count_d        = count;
        busy_d         = busy;
        done_d         = 1'b0;
        packed_ascii_d = packed_ascii;
        case (state)
            IDLE: begin
                if (do_clear)      count_d = '0;
                else if (do_write) count_d = count + (AW+1)'(1);
                if (do_start) begin
                    hold_d         = '0;
                    frame_idx_d    = '0;
                    busy_d         = 1'b1;
                    packed_ascii_d = mem[0];
                end
            end
            SHOW: begin
                if (stop) begin
                    hold_d         = '0;
                    frame_idx_d    = '0;
                    busy_d         = 1'b0;
                    packed_ascii_d = BLANK;
                end else if (hold_end) begin
                    hold_d = '0;
                    if (!last_frame) begin
                        frame_idx_d    = idx_inc;
                        packed_ascii_d = mem[idx_inc];
                    end else if (loop) begin
                        frame_idx_d    = '0;
                        packed_ascii_d = mem[0];
                    end else begin
                        frame_idx_d    = '0;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                        packed_ascii_d = BLANK;
                    end
                end else begin
                    hold_d = hold + C'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            hold         <= '0;
            frame_idx    <= '0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            packed_ascii <= BLANK;
        end else begin
            hold         <= hold_d;
            frame_idx    <= frame_idx_d;
            count        <= count_d;
            busy         <= busy_d;
            done         <= done_d;
            packed_ascii <= packed_ascii_d;
        end
    end

    // Buffer contents survive reset; only count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_write) mem[count[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_display_message_sequencer.sv
// Randomized bench for display_message_sequencer: frames kept in a queue model,
// expected display sequence expanded into a scoreboard queue per playback.
module tb_display_message_sequencer;

    localparam int          HOLD  = 4;
    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam logic [31:0] BLANK = 32'h20202020;

    logic          clk, arst;
    logic          wr_en, wr_ready, clear, start, stop, loop, busy, done;
    logic [31:0]   wr_data, packed_ascii;
    logic [AW-1:0] frame_idx;
    logic [AW:0]   count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] frames[$];

    display_message_sequencer #(.HOLD_LAST(35'd3), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .arst(arst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .clear(clear), .start(start), .stop(stop), .loop(loop), .busy(busy),
        .frame_idx(frame_idx), .count(count), .packed_ascii(packed_ascii), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        frames.delete();
        n_tests++;
        if (count !== '0) begin
            $display("FAIL clear_count: got %0d want 0", count); n_fail++;
        end
    endtask

    task automatic write_frame(input logic [31:0] d);
        n_tests++;
        if (wr_ready !== 1'b1) begin
            $display("FAIL wr_ready_before_write: got %b want 1", wr_ready); n_fail++;
        end
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (frames.size() < DEPTH) frames.push_back(d);
        n_tests++;
        if (count !== (AW+1)'(frames.size())) begin
            $display("FAIL write_count: got %0d want %0d", count, frames.size()); n_fail++;
        end
    endtask

    // Called right after the edge that accepted start; walks the expected display sequence.
    task automatic check_playback(input bit lp, input int n_loop_checks);
        logic [31:0] exp_q[$];
        int n = frames.size();
        int total = lp ? n_loop_checks : HOLD * n;
        for (int i = 0; i < total; i++) exp_q.push_back(frames[(i / HOLD) % n]);
        for (int i = 0; i < total; i++) begin
            logic [31:0] exp_pa = exp_q.pop_front();
            n_tests++;
            if (packed_ascii !== exp_pa || frame_idx !== AW'((i / HOLD) % n) || busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL play[%0d]: got pa=%h idx=%0d busy=%b done=%b want pa=%h idx=%0d busy=1 done=0",
                         i, packed_ascii, frame_idx, busy, done, exp_pa, (i / HOLD) % n);
                n_fail++;
            end
            // These must be ignored while showing.
            wr_en = 1'($urandom_range(0, 1)); clear = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1)); wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0; clear = 1'b0; start = 1'b0;
        if (!lp) begin
            n_tests++;
            if (done !== 1'b1 || busy !== 1'b0 || packed_ascii !== BLANK || frame_idx !== '0) begin
                $display("FAIL end_of_seq: got done=%b busy=%b pa=%h idx=%0d want done=1 busy=0 pa=%h idx=0",
                         done, busy, packed_ascii, frame_idx, BLANK);
                n_fail++;
            end
            tick();
            n_tests++;
            if (done !== 1'b0 || count !== (AW+1)'(n)) begin
                $display("FAIL done_pulse_width: got done=%b count=%0d want done=0 count=%0d", done, count, n);
                n_fail++;
            end
        end
    endtask

    task automatic play_once();
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_playback(1'b0, 0);
    endtask

    task automatic test_reset();
        arst = 1'b0;
        #23;
        n_tests++;
        if (packed_ascii !== BLANK || busy !== 1'b0 || count !== '0 || wr_ready !== 1'b1 || done !== 1'b0 || frame_idx !== '0) begin
            $display("FAIL reset: got pa=%h busy=%b count=%0d wr_ready=%b done=%b idx=%0d want pa=%h busy=0 count=0 wr_ready=1 done=0 idx=0",
                     packed_ascii, busy, count, wr_ready, done, frame_idx, BLANK);
            n_fail++;
        end
        @(negedge clk);
        arst = 1'b1;
        tick();
    endtask

    task automatic test_basic_sequence();
        do_clear();
        write_frame("HELO"); write_frame("ABCD"); write_frame("1234");
        play_once();
    endtask

    task automatic test_random_sequences();
        for (int it = 0; it < 5; it++) begin
            int n = $urandom_range(1, DEPTH);
            do_clear();
            for (int k = 0; k < n; k++) write_frame($urandom);
            play_once();
        end
    endtask

    task automatic test_loop_and_stop();
        for (int it = 0; it < 3; it++) begin
            int n = (it == 0) ? 3 : $urandom_range(1, 4);
            int k;
            do_clear();
            if (it == 0) begin
                write_frame("HELO"); write_frame("ABCD"); write_frame("1234");
            end else begin
                for (int j = 0; j < n; j++) write_frame($urandom);
            end
            k = 2 * HOLD * n + $urandom_range(1, HOLD * n - 1);
            loop = 1'b1; start = 1'b1;
            tick();
            start = 1'b0;
            check_playback(1'b1, k);
            stop = 1'b1;
            tick();
            stop = 1'b0; loop = 1'b0;
            n_tests++;
            if (packed_ascii !== BLANK || busy !== 1'b0 || done !== 1'b0 || frame_idx !== '0 || count !== (AW+1)'(n)) begin
                $display("FAIL stop: got pa=%h busy=%b done=%b idx=%0d count=%0d want pa=%h busy=0 done=0 idx=0 count=%0d",
                         packed_ascii, busy, done, frame_idx, count, BLANK, n);
                n_fail++;
            end
            tick();
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL stop_no_done: got done=%b busy=%b want 0 0", done, busy); n_fail++;
            end
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int k = 0; k < DEPTH; k++) write_frame($urandom);
        n_tests++;
        if (wr_ready !== 1'b0 || count !== (AW+1)'(DEPTH)) begin
            $display("FAIL full: got wr_ready=%b count=%0d want 0 %0d", wr_ready, count, DEPTH); n_fail++;
        end
        wr_en = 1'b1; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (count !== (AW+1)'(DEPTH)) begin
            $display("FAIL overflow_count: got %0d want %0d", count, DEPTH); n_fail++;
        end
        play_once();
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || packed_ascii !== BLANK) begin
            $display("FAIL start_empty: got busy=%b pa=%h want 0 %h", busy, packed_ascii, BLANK); n_fail++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || count !== '0 || wr_ready !== 1'b1) begin
            $display("FAIL stop_idle: got busy=%b count=%0d wr_ready=%b want 0 0 1", busy, count, wr_ready); n_fail++;
        end
    endtask

    task automatic test_start_with_write();
        do_clear();
        start = 1'b1; wr_en = 1'b1; wr_data = "WXYZ";
        tick();
        start = 1'b0; wr_en = 1'b0;
        frames.push_back("WXYZ");
        n_tests++;
        if (count !== (AW+1)'(1) || busy !== 1'b0) begin
            $display("FAIL start_write_empty: got count=%0d busy=%b want 1 0", count, busy); n_fail++;
        end
        loop = 1'b0; start = 1'b1; wr_en = 1'b1; wr_data = "ABCD";
        tick();
        start = 1'b0; wr_en = 1'b0;
        frames.push_back("ABCD");
        n_tests++;
        if (count !== (AW+1)'(2)) begin
            $display("FAIL start_write_count: got %0d want 2", count); n_fail++;
        end
        check_playback(1'b0, 0);
    endtask

    task automatic test_async_reset();
        do_clear();
        write_frame($urandom); write_frame($urandom);
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2;
        arst = 1'b0;
        #1;
        n_tests++;
        if (packed_ascii !== BLANK || busy !== 1'b0 || count !== '0 || frame_idx !== '0 || done !== 1'b0 || wr_ready !== 1'b1) begin
            $display("FAIL async_reset: got pa=%h busy=%b count=%0d idx=%0d done=%b wr_ready=%b want pa=%h 0 0 0 0 1",
                     packed_ascii, busy, count, frame_idx, done, wr_ready, BLANK);
            n_fail++;
        end
        loop = 1'b0;
        frames.delete();
        @(negedge clk);
        arst = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || packed_ascii !== BLANK) begin
            $display("FAIL after_reset: got busy=%b pa=%h want 0 %h", busy, packed_ascii, BLANK); n_fail++;
        end
    endtask

    initial begin
        wr_en = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        test_reset();
        test_basic_sequence();
        test_random_sequences();
        test_loop_and_stop();
        test_overflow();
        test_start_with_write();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_message_sequencer.md
Name: display_message_sequencer

Overview:
Controller that sits in front of the 4-digit ASCII seven-segment display path and schedules what it shows. It buffers up to DEPTH packed 4-character ASCII frames, written by a requester over a ready/enable handshake. On start it plays the frames in write order, holding each for a fixed number of clock cycles. The sequence then either stops with a done pulse or loops. Its packed_ascii output drives the display's packed ASCII input directly.

Parameters:
CRYSTAL, 100, clock frequency in MHz
HOLD_SEC, 1, seconds each frame is shown
C, 35, width of the hold cycle counter
HOLD_LAST, (CRYSTAL*1_000_000*HOLD_SEC)-1, terminal count of the hold counter; overridden to small values in simulation
DEPTH, 8, frame buffer entries (power of 2)
AW, 3, log2(DEPTH)
BLANK, 32'h20202020, frame driven when not playing (four ASCII spaces)

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous, active-low reset
wr_en  in  1  write frame; accepted only when wr_ready=1
wr_data  in  32  frame to write; [31:24] is the leftmost character
wr_ready  out  1  buffer accepts a write this cycle
clear  in  1  empty the buffer; honoured only in IDLE
start  in  1  begin playback
stop  in  1  abort playback
loop  in  1  replay from frame 0 after the last frame; sampled at each end of sequence
busy  out  1  playback in progress
frame_idx  out  AW  index of the frame being shown
count  out  AW+1  number of stored frames, 0..DEPTH
packed_ascii  out  32  frame to display (registered)
done  out  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Reset (arst=0, asynchronous): state=IDLE, count=0, frame_idx=0, hold counter=0, busy=0, done=0, packed_ascii=BLANK. Buffer contents are don't-care.
- All outputs are registered. wr_ready is combinational: (state==IDLE) && (count<DEPTH).
- States: IDLE, SHOW.
- IDLE, write: wr_en && wr_ready stores wr_data at mem[count] and increments count. wr_en while wr_ready=0 is ignored with no side effects.
- IDLE, clear: clear sets count=0. If clear and wr_en are asserted together, clear wins and the write is dropped.
- IDLE, start: start with pre-edge count>0 moves to SHOW with frame_idx=0, hold counter=0, busy=1, and packed_ascii=mem[0], all visible after that same edge. start with count==0 is ignored.
- IDLE, start with write: start and a write in the same cycle are both honoured. The start decision uses the pre-write count, and the new frame becomes part of the sequence.
- SHOW, hold: the hold counter increments every cycle. Each frame is shown for exactly HOLD_LAST+1 cycles.
- SHOW, frame advance: at hold==HOLD_LAST the counter returns to 0. If frame_idx<count-1, frame_idx increments and packed_ascii=mem[frame_idx+1] on the next edge.
- SHOW, end of sequence (frame_idx==count-1 at hold==HOLD_LAST):
  - loop=1: frame_idx=0, packed_ascii=mem[0], remain in SHOW, no done pulse.
  - loop=0: go to IDLE, busy=0, packed_ascii=BLANK, frame_idx=0, done=1 for exactly one cycle.
- SHOW, stop: stop goes to IDLE on the next edge with busy=0, packed_ascii=BLANK, frame_idx=0 and no done pulse. stop has priority over a coincident frame advance or end of sequence. The buffer is preserved.
- SHOW, ignored inputs: start, clear and wr_en are ignored in SHOW.
- Single frame: count==1 shows mem[0] for one hold period, then ends or, if loop=1, repeats it indefinitely.
- stop in IDLE has no effect. Reset mid-playback forces all reset values immediately.

Test Plan:
- Reset with HOLD_LAST=3: after arst release, packed_ascii=20202020, busy=0, count=0, wr_ready=1.
- Write "HELO", "ABCD", "1234", then pulse start with loop=0: packed_ascii shows each frame for exactly 4 cycles in order with frame_idx 0,1,2. One cycle after the third frame, done=1 for 1 cycle, busy=0, packed_ascii=20202020.
- Same 3 frames with loop=1: after "1234", "HELO" reappears with no gap and done stays 0. Assert stop mid-frame: next edge gives IDLE, BLANK, done=0, and count still 3.
- Write 9 frames: the first 8 are accepted, and on the 9th wr_ready=0, count stays 8 and mem is unchanged. clear returns count to 0, and a subsequent start is ignored (busy stays 0).
- With count=0, start and a write of "WXYZ" in the same cycle: write accepted (count=1) and start ignored. With count=1, start and a write of "ABCD" in the same cycle: playback shows the stored frame then "ABCD".
- Assert arst=0 asynchronously mid-frame during playback: outputs go to reset values without waiting for a clock edge, and count=0.
